// File: rtl/leg_exc_pkg.sv
// -----------------------------------------------------------------------------
// leg_exc_pkg
//   Shared definitions for ARM exception entry: exception type encoding,
//   processor mode values, per-type vector and link offsets, CPSR bit
//   positions, and small lookup helpers that map an exception type to its
//   constants.
// -----------------------------------------------------------------------------
package leg_exc_pkg;

    // Exception kinds the sequencer can take. EXC_NONE means nothing eligible.
    typedef enum logic [2:0] {
        EXC_NONE   = 3'd0,
        EXC_UNDEF  = 3'd1,
        EXC_SWI    = 3'd2,
        EXC_PABORT = 3'd3,
        EXC_DABORT = 3'd4,
        EXC_IRQ    = 3'd5,
        EXC_FIQ    = 3'd6
    } exc_type_t;

    // Processor mode encodings (CPSR[4:0]).
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // Vector table offsets, OR-ed onto the selected vector base.
    localparam logic [31:0] VEC_OFF_UNDEF  = 32'h0000_0004;
    localparam logic [31:0] VEC_OFF_SWI    = 32'h0000_0008;
    localparam logic [31:0] VEC_OFF_PABORT = 32'h0000_000C;
    localparam logic [31:0] VEC_OFF_DABORT = 32'h0000_0010;
    localparam logic [31:0] VEC_OFF_IRQ    = 32'h0000_0018;
    localparam logic [31:0] VEC_OFF_FIQ    = 32'h0000_001C;

    localparam logic [31:0] VEC_BASE_LOW  = 32'h0000_0000;
    localparam logic [31:0] VEC_BASE_HIGH = 32'hFFFF_0000;

    // Amount added to the captured PC to form the banked R14 value.
    localparam logic [31:0] LINK_OFF_DEFAULT = 32'd4;
    localparam logic [31:0] LINK_OFF_DABORT  = 32'd8;

    // CPSR field positions: [11:8] NZCV, [7] I, [6] F, [5] T, [4:0] mode.
    localparam int CPSR_NZCV_MSB = 11;
    localparam int CPSR_NZCV_LSB = 8;
    localparam int CPSR_I_BIT    = 7;
    localparam int CPSR_F_BIT    = 6;
    localparam int CPSR_T_BIT    = 5;
    localparam int CPSR_MODE_MSB = 4;
    localparam int CPSR_MODE_LSB = 0;

    // Register-file address of the link register; the decoder maps it to
    // the bank of whatever mode the CPSR holds when the write lands.
    localparam logic [3:0] LR_ADDR = 4'hE;

    function automatic logic [4:0] exc_mode(input exc_type_t t);
        case (t)
            EXC_UNDEF:  return MODE_UND;
            EXC_SWI:    return MODE_SVC;
            EXC_PABORT: return MODE_ABT;
            EXC_DABORT: return MODE_ABT;
            EXC_IRQ:    return MODE_IRQ;
            EXC_FIQ:    return MODE_FIQ;
            default:    return MODE_USR;
        endcase
    endfunction

    function automatic logic [31:0] exc_vec_off(input exc_type_t t);
        case (t)
            EXC_UNDEF:  return VEC_OFF_UNDEF;
            EXC_SWI:    return VEC_OFF_SWI;
            EXC_PABORT: return VEC_OFF_PABORT;
            EXC_DABORT: return VEC_OFF_DABORT;
            EXC_IRQ:    return VEC_OFF_IRQ;
            EXC_FIQ:    return VEC_OFF_FIQ;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] exc_link_off(input exc_type_t t);
        return (t == EXC_DABORT) ? LINK_OFF_DABORT : LINK_OFF_DEFAULT;
    endfunction

    // One-hot acknowledge, bit order {fiq, irq, dabort, pabort, swi, undef}.
    function automatic logic [5:0] exc_ack_onehot(input exc_type_t t);
        case (t)
            EXC_UNDEF:  return 6'b000001;
            EXC_SWI:    return 6'b000010;
            EXC_PABORT: return 6'b000100;
            EXC_DABORT: return 6'b001000;
            EXC_IRQ:    return 6'b010000;
            EXC_FIQ:    return 6'b100000;
            default:    return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/exc_priority_select.sv
// -----------------------------------------------------------------------------
// exc_priority_select
//   Combinational arbitration of pending exception requests. IRQ and FIQ are
//   masked by the CPSR I and F bits; the survivors are priority encoded
//   DAbort > FIQ > IRQ > PAbort > Undef > SWI.
//
// Ports
//   req_undef/req_swi/req_pabort/req_dabort  synchronous exception requests
//   irq_line/fiq_line                        interrupt lines
//   cpsr_i/cpsr_f                            current CPSR interrupt masks
//   winner                                   highest-priority eligible type
// -----------------------------------------------------------------------------
module exc_priority_select
    import leg_exc_pkg::*;
(
    input  logic      req_undef,
    input  logic      req_swi,
    input  logic      req_pabort,
    input  logic      req_dabort,
    input  logic      irq_line,
    input  logic      fiq_line,
    input  logic      cpsr_i,
    input  logic      cpsr_f,
    output exc_type_t winner
);

    logic irq_eligible;
    logic fiq_eligible;

    assign irq_eligible = irq_line & ~cpsr_i;
    assign fiq_eligible = fiq_line & ~cpsr_f;

    always_comb begin
        // NOTE: defaulting the output before the if-chain keeps this block
        // purely combinational; a path that leaves it unassigned infers a latch.
        winner = EXC_NONE;
        if (req_dabort) begin
            winner = EXC_DABORT;
        end else if (fiq_eligible) begin
            winner = EXC_FIQ;
        end else if (irq_eligible) begin
            winner = EXC_IRQ;
        end else if (req_pabort) begin
            winner = EXC_PABORT;
        end else if (req_undef) begin
            winner = EXC_UNDEF;
        end else if (req_swi) begin
            winner = EXC_SWI;
        end
    end

endmodule

// File: rtl/exception_entry_sequencer.sv
// -----------------------------------------------------------------------------
// exception_entry_sequencer
//   Multi-cycle ARM exception entry. In IDLE the highest-priority eligible
//   request is captured together with the PC and CPSR. The sequencer then
//   stalls fetch/decode until the pipeline drains and issues, one per cycle:
//     SWITCH : SPSR save (banked by new mode) and CPSR mode switch
//     LINK   : write of R14 (address 4'hE) = captured PC + link offset
//     VECTOR : PC redirect to the vector, full flush, one-hot acknowledge
//   The R14 write follows the CPSR switch so the decode-stage address decoder
//   already resolves 4'hE to the new mode's banked link register.
//
// Parameters
//   HIGH_VECTORS  1 = vector base 32'hFFFF0000, 0 = vector base 32'h00000000
//   CPSR_W        CPSR width ([11:8] NZCV, [7] I, [6] F, [5] T, [4:0] mode)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ExcReq*                    level exception requests, held until acked
//   IrqIn, FiqIn               level interrupt lines
//   ExcPCIn                    PC of the excepting / next instruction
//   CPSRIn                     current CPSR
//   PipeDrained                nothing uncommitted remains past decode
//   StallF                     holds fetch/decode while the sequence runs
//   FlushAll                   one-cycle flush of all stages (VECTOR)
//   CPSRWrEn/CPSRWrData        CPSR write port (SWITCH)
//   SPSRWrEn/Mode/Data         banked SPSR write port (SWITCH)
//   RegWrEn/RegWrAddr4b/Data   register-file write of R14 (LINK)
//   PCRedirect/PCTarget        one-cycle PC load with vector address (VECTOR)
//   ExcAck                     one-hot {fiq, irq, dabort, pabort, swi, undef}
//   Busy                       sequencer is not in IDLE
// -----------------------------------------------------------------------------
module exception_entry_sequencer
    import leg_exc_pkg::*;
#(
    parameter bit HIGH_VECTORS = 1'b0,
    parameter int CPSR_W       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ExcReqUndef,
    input  logic              ExcReqSWI,
    input  logic              ExcReqPAbort,
    input  logic              ExcReqDAbort,
    input  logic              IrqIn,
    input  logic              FiqIn,
    input  logic [31:0]       ExcPCIn,
    input  logic [CPSR_W-1:0] CPSRIn,
    input  logic              PipeDrained,
    output logic              StallF,
    output logic              FlushAll,
    output logic              CPSRWrEn,
    output logic [CPSR_W-1:0] CPSRWrData,
    output logic              SPSRWrEn,
    output logic [4:0]        SPSRWrMode,
    output logic [CPSR_W-1:0] SPSRWrData,
    output logic              RegWrEn,
    output logic [3:0]        RegWrAddr4b,
    output logic [31:0]       RegWrData,
    output logic              PCRedirect,
    output logic [31:0]       PCTarget,
    output logic [5:0]        ExcAck,
    output logic              Busy
);

    // Sequencer states.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_SWITCH = 3'd2;
    localparam logic [2:0] ST_LINK   = 3'd3;
    localparam logic [2:0] ST_VECTOR = 3'd4;

    localparam logic [31:0] VEC_BASE = HIGH_VECTORS ? VEC_BASE_HIGH : VEC_BASE_LOW;

    logic [2:0]        state;
    exc_type_t         winner;
    exc_type_t         cap_type;
    logic [31:0]       cap_pc;
    logic [CPSR_W-1:0] cap_cpsr;
    logic [4:0]        new_mode;
    logic [CPSR_W-1:0] new_cpsr;

    // ------------------------------------------------------------------
    // Arbitration of the live request lines against the live CPSR masks.
    // Only consulted in IDLE; after capture the winner is frozen.
    // ------------------------------------------------------------------
    exc_priority_select u_priority_select (
        .req_undef  (ExcReqUndef),
        .req_swi    (ExcReqSWI),
        .req_pabort (ExcReqPAbort),
        .req_dabort (ExcReqDAbort),
        .irq_line   (IrqIn),
        .fiq_line   (FiqIn),
        .cpsr_i     (CPSRIn[CPSR_I_BIT]),
        .cpsr_f     (CPSRIn[CPSR_F_BIT]),
        .winner     (winner)
    );

    // ------------------------------------------------------------------
    // State and capture registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= ST_IDLE;
            // NOTE: the capture registers are cleared on reset as well so an
            // aborted entry leaves no stale type/PC/CPSR behind.
            cap_type <= EXC_NONE;
            cap_pc   <= '0;
            cap_cpsr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (winner != EXC_NONE) begin
                        cap_type <= winner;
                        cap_pc   <= ExcPCIn;
                        cap_cpsr <= CPSRIn;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No timeout: the pipeline is guaranteed to drain.
                    if (PipeDrained) begin
                        state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: state <= ST_LINK;
                ST_LINK:   state <= ST_VECTOR;
                ST_VECTOR: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // New CPSR: keep NZCV, set I, clear T, set F only for FIQ (otherwise
    // keep it), and switch mode.
    // ------------------------------------------------------------------
    assign new_mode = exc_mode(cap_type);

    always_comb begin
        new_cpsr             = cap_cpsr;
        new_cpsr[CPSR_I_BIT] = 1'b1;
        new_cpsr[CPSR_T_BIT] = 1'b0;
        if (cap_type == EXC_FIQ) begin
            new_cpsr[CPSR_F_BIT] = 1'b1;
        end
        new_cpsr[CPSR_MODE_MSB:CPSR_MODE_LSB] = new_mode;
    end

    // ------------------------------------------------------------------
    // Output decode. Each strobe belongs to exactly one state, so at most
    // one of SPSR/CPSR/R14/PC writes is active in any cycle (the SPSR and
    // CPSR writes share SWITCH and target different registers).
    // ------------------------------------------------------------------
    always_comb begin
        StallF      = 1'b0;
        FlushAll    = 1'b0;
        CPSRWrEn    = 1'b0;
        CPSRWrData  = '0;
        SPSRWrEn    = 1'b0;
        SPSRWrMode  = '0;
        SPSRWrData  = '0;
        RegWrEn     = 1'b0;
        RegWrAddr4b = '0;
        RegWrData   = '0;
        PCRedirect  = 1'b0;
        PCTarget    = '0;
        ExcAck      = '0;
        Busy        = (state != ST_IDLE);

        case (state)
            ST_DRAIN: begin
                StallF = 1'b1;
            end
            ST_SWITCH: begin
                StallF     = 1'b1;
                SPSRWrEn   = 1'b1;
                SPSRWrMode = new_mode;
                SPSRWrData = cap_cpsr;
                CPSRWrEn   = 1'b1;
                CPSRWrData = new_cpsr;
            end
            ST_LINK: begin
                StallF      = 1'b1;
                RegWrEn     = 1'b1;
                RegWrAddr4b = LR_ADDR;
                // 32-bit add wraps naturally (0xFFFFFFFC + 4 -> 0).
                RegWrData   = cap_pc + exc_link_off(cap_type);
            end
            ST_VECTOR: begin
                StallF     = 1'b1;
                FlushAll   = 1'b1;
                PCRedirect = 1'b1;
                PCTarget   = VEC_BASE | exc_vec_off(cap_type);
                ExcAck     = exc_ack_onehot(cap_type);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_exception_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exception_entry_sequencer
//   Two instances (low and high vectors) share all inputs. A small reference
//   model holds the pending request set and the CPSR the core would present;
//   from the architectural rules it predicts the winner and the full
//   output trace of every entry (drain, switch, link, vector, idle).
// -----------------------------------------------------------------------------
module tb_exception_entry_sequencer;

    localparam int PH_IDLE   = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_SWITCH = 2;
    localparam int PH_LINK   = 3;
    localparam int PH_VECTOR = 4;

    // Request bit index: 0 undef, 1 swi, 2 pabort, 3 dabort, 4 irq, 5 fiq.
    logic [4:0]  mode_tab [6] = '{5'b11011, 5'b10011, 5'b10111, 5'b10111, 5'b10010, 5'b10001};
    logic [31:0] vec_tab  [6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C};
    logic [31:0] link_tab [6] = '{32'd4, 32'd4, 32'd4, 32'd8, 32'd4, 32'd4};
    int          prio_tab [6] = '{3, 5, 4, 2, 0, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  req_vec;
    logic [31:0] exc_pc;
    logic [11:0] cpsr_in;
    logic        pipe_drained;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Low-vector instance outputs.
    logic        lo_stall, lo_flush, lo_cpsr_we, lo_spsr_we, lo_reg_we, lo_pc_redir, lo_busy;
    logic [11:0] lo_cpsr_wd, lo_spsr_wd;
    logic [4:0]  lo_spsr_mode;
    logic [3:0]  lo_reg_addr;
    logic [31:0] lo_reg_wd, lo_pc_tgt;
    logic [5:0]  lo_ack;
    // High-vector instance outputs.
    logic        hi_stall, hi_flush, hi_cpsr_we, hi_spsr_we, hi_reg_we, hi_pc_redir, hi_busy;
    logic [11:0] hi_cpsr_wd, hi_spsr_wd;
    logic [4:0]  hi_spsr_mode;
    logic [3:0]  hi_reg_addr;
    logic [31:0] hi_reg_wd, hi_pc_tgt;
    logic [5:0]  hi_ack;

    logic [109:0] lo_bundle, hi_bundle;
    assign lo_bundle = {lo_stall, lo_flush, lo_cpsr_we, lo_cpsr_wd, lo_spsr_we, lo_spsr_mode,
                        lo_spsr_wd, lo_reg_we, lo_reg_addr, lo_reg_wd, lo_pc_redir, lo_pc_tgt,
                        lo_ack, lo_busy};
    assign hi_bundle = {hi_stall, hi_flush, hi_cpsr_we, hi_cpsr_wd, hi_spsr_we, hi_spsr_mode,
                        hi_spsr_wd, hi_reg_we, hi_reg_addr, hi_reg_wd, hi_pc_redir, hi_pc_tgt,
                        hi_ack, hi_busy};

    exception_entry_sequencer #(.HIGH_VECTORS(1'b0), .CPSR_W(12)) u_dut_lo (
        .clk(clk), .reset(reset),
        .ExcReqUndef(req_vec[0]), .ExcReqSWI(req_vec[1]), .ExcReqPAbort(req_vec[2]),
        .ExcReqDAbort(req_vec[3]), .IrqIn(req_vec[4]), .FiqIn(req_vec[5]),
        .ExcPCIn(exc_pc), .CPSRIn(cpsr_in), .PipeDrained(pipe_drained),
        .StallF(lo_stall), .FlushAll(lo_flush), .CPSRWrEn(lo_cpsr_we), .CPSRWrData(lo_cpsr_wd),
        .SPSRWrEn(lo_spsr_we), .SPSRWrMode(lo_spsr_mode), .SPSRWrData(lo_spsr_wd),
        .RegWrEn(lo_reg_we), .RegWrAddr4b(lo_reg_addr), .RegWrData(lo_reg_wd),
        .PCRedirect(lo_pc_redir), .PCTarget(lo_pc_tgt), .ExcAck(lo_ack), .Busy(lo_busy)
    );

    exception_entry_sequencer #(.HIGH_VECTORS(1'b1), .CPSR_W(12)) u_dut_hi (
        .clk(clk), .reset(reset),
        .ExcReqUndef(req_vec[0]), .ExcReqSWI(req_vec[1]), .ExcReqPAbort(req_vec[2]),
        .ExcReqDAbort(req_vec[3]), .IrqIn(req_vec[4]), .FiqIn(req_vec[5]),
        .ExcPCIn(exc_pc), .CPSRIn(cpsr_in), .PipeDrained(pipe_drained),
        .StallF(hi_stall), .FlushAll(hi_flush), .CPSRWrEn(hi_cpsr_we), .CPSRWrData(hi_cpsr_wd),
        .SPSRWrEn(hi_spsr_we), .SPSRWrMode(hi_spsr_mode), .SPSRWrData(hi_spsr_wd),
        .RegWrEn(hi_reg_we), .RegWrAddr4b(hi_reg_addr), .RegWrData(hi_reg_wd),
        .PCRedirect(hi_pc_redir), .PCTarget(hi_pc_tgt), .ExcAck(hi_ack), .Busy(hi_busy)
    );

    // ---------------- reference model ----------------
    function automatic bit eligible(input int k);
        if (!req_vec[k]) return 1'b0;
        if (k == 4 && cpsr_in[7]) return 1'b0;
        if (k == 5 && cpsr_in[6]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pick();
        for (int i = 0; i < 6; i++) begin
            if (eligible(prio_tab[i])) return prio_tab[i];
        end
        return -1;
    endfunction

    function automatic logic [11:0] cpsr_after(input int t, input logic [11:0] c);
        return {c[11:8], 1'b1, (t == 5) ? 1'b1 : c[6], 1'b0, mode_tab[t]};
    endfunction

    function automatic logic [109:0] expect_bundle(input int ph, input int t, input logic [31:0] pc,
                                                   input logic [11:0] c, input bit hv);
        logic        stall, flush, cwe, swe, rwe, redir, busy;
        logic [11:0] cwd, swd;
        logic [4:0]  smode;
        logic [3:0]  raddr;
        logic [31:0] rwd, tgt;
        logic [5:0]  ack;
        stall = (ph != PH_IDLE); busy = (ph != PH_IDLE);
        flush = 0; cwe = 0; swe = 0; rwe = 0; redir = 0;
        cwd = 0; swd = 0; smode = 0; raddr = 0; rwd = 0; tgt = 0; ack = 0;
        if (ph == PH_SWITCH) begin
            swe = 1; smode = mode_tab[t]; swd = c;
            cwe = 1; cwd = cpsr_after(t, c);
        end
        if (ph == PH_LINK) begin
            rwe = 1; raddr = 4'hE; rwd = pc + link_tab[t];
        end
        if (ph == PH_VECTOR) begin
            redir = 1; flush = 1;
            tgt = (hv ? 32'hFFFF_0000 : 32'h0) | vec_tab[t];
            ack = 6'd1 << t;
        end
        return {stall, flush, cwe, cwd, swe, smode, swd, rwe, raddr, rwd, redir, tgt, ack, busy};
    endfunction

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [109:0] obs, input logic [109:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input int ph, input int t, input logic [31:0] pc,
                        input logic [11:0] c);
        @(negedge clk);
        check_vec({tag, " lo"}, lo_bundle, expect_bundle(ph, t, pc, c, 1'b0));
        check_vec({tag, " hi"}, hi_bundle, expect_bundle(ph, t, pc, c, 1'b1));
        checks++;
        assert ($onehot0({lo_spsr_we, lo_reg_we, lo_pc_redir}) &&
                $onehot0({lo_cpsr_we, lo_reg_we, lo_pc_redir})) else begin
            failures++;
            $error("FAIL %s strobe_overlap observed=%b expected=at most one of reg/pc with spsr/cpsr",
                   tag, {lo_spsr_we, lo_cpsr_we, lo_reg_we, lo_pc_redir});
        end
    endtask

    // Called right after a negedge with the DUT in IDLE; the request set
    // and CPSR in place now are what the next edge arbitrates.
    task automatic do_entry(input string tag, input logic [31:0] pc, input int drain,
                            input logic [5:0] inject, input bit abort_link);
        int          t;
        logic [31:0] cap_pc;
        logic [11:0] cap_cpsr;
        t = pick();
        if (t < 0) return;
        exc_pc   = pc;
        cap_pc   = pc;
        cap_cpsr = cpsr_in;
        for (int i = 0; i <= drain; i++) begin
            step({tag, " drain"}, PH_DRAIN, t, cap_pc, cap_cpsr);
            if (i == 0) req_vec = req_vec | inject;
            pipe_drained = (i == drain);
            exc_pc  = $urandom;
            cpsr_in = 12'($urandom);
        end
        step({tag, " switch"}, PH_SWITCH, t, cap_pc, cap_cpsr);
        cpsr_in      = cpsr_after(t, cap_cpsr);
        pipe_drained = 1'($urandom);
        step({tag, " link"}, PH_LINK, t, cap_pc, cap_cpsr);
        if (abort_link) begin
            reset   = 1'b1;
            req_vec = '0;
            step({tag, " reset"}, PH_IDLE, 0, 32'h0, 12'h0);
            reset = 1'b0;
            step({tag, " idle"}, PH_IDLE, 0, 32'h0, 12'h0);
            return;
        end
        step({tag, " vector"}, PH_VECTOR, t, cap_pc, cap_cpsr);
        req_vec[t] = 1'b0;
        step({tag, " idle"}, PH_IDLE, 0, 32'h0, 12'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time_limit observed=expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_vec      = '0;
        exc_pc       = '0;
        cpsr_in      = '0;
        pipe_drained = 1'b1;
        repeat (2) @(negedge clk);
        step("reset state", PH_IDLE, 0, 32'h0, 12'h0);
        reset = 1'b0;
        step("post reset", PH_IDLE, 0, 32'h0, 12'h0);

        // IRQ alone: CPSR 0x010 -> 0x092, R14 0x104, vector 0x18.
        cpsr_in = 12'h010; req_vec = 6'b010000;
        do_entry("irq", 32'h0000_0100, 0, 6'b0, 1'b0);

        // Masked IRQ stays idle; FIQ then enters (CPSR 0x0D1, vector 0x1C).
        cpsr_in = 12'h090; req_vec = 6'b010000;
        repeat (4) step("masked irq", PH_IDLE, 0, 32'h0, 12'h0);
        req_vec[5] = 1'b1;
        do_entry("fiq", 32'h0000_0200, 0, 6'b0, 1'b0);
        req_vec = '0;
        step("idle", PH_IDLE, 0, 32'h0, 12'h0);

        // DAbort + FIQ + SWI together: DAbort, then FIQ, then SWI.
        cpsr_in = 12'h010; req_vec = 6'b101010;
        do_entry("multi 1st", 32'h0000_1000, 0, 6'b0, 1'b0);
        do_entry("multi 2nd", 32'h0000_1004, 0, 6'b0, 1'b0);
        do_entry("multi 3rd", 32'h0000_1008, 0, 6'b0, 1'b0);

        // Drain wait of 5 cycles; DAbort raised mid-drain is not re-arbitrated.
        cpsr_in = 12'h1D3; req_vec = 6'b000001;
        do_entry("drain wait", 32'h0000_3000, 5, 6'b001000, 1'b0);
        do_entry("late dabort", 32'h0000_3010, 0, 6'b0, 1'b0);

        // Reset during LINK aborts the entry.
        cpsr_in = 12'h010; req_vec = 6'b000010;
        do_entry("abort", 32'h0000_0400, 1, 6'b0, 1'b1);

        // Undef at the top of memory: R14 wraps to 0, high vector 0xFFFF0004.
        cpsr_in = 12'h010; req_vec = 6'b000001;
        do_entry("undef wrap", 32'hFFFF_FFFC, 0, 6'b0, 1'b0);

        // Randomised request sets, CPSR values, PCs and drain lengths.
        for (int trial = 0; trial < 40; trial++) begin
            req_vec = 6'($urandom);
            cpsr_in = 12'($urandom);
            for (int k = 0; k < 8 && pick() >= 0; k++) begin
                do_entry("rand", $urandom, int'($urandom_range(0, 3)),
                         (k == 0) ? 6'($urandom & $urandom) : 6'b0, 1'b0);
            end
            req_vec = '0;
            step("rand idle", PH_IDLE, 0, 32'h0, 12'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
